// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle floating-point add/multiply for any {sign, EXP_W, MAN_W} format, NZCV flags.
// Latency: out_valid 4 cycles after the input handshake; one op in flight, 5-cycle throughput.
// Backpressure: holds result/flags in DONE while out_ready is low; in_ready only high in IDLE.
// Build option FPU_SEQ_RNE_EN: round to nearest even in NORM; undefined truncates toward zero.
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int SW = MAN_W + 5;      // carry, hidden, mantissa, guard/round/sticky
    localparam int XW = EXP_W + 8;      // signed working exponent, room for under/overflow
    localparam int PW = 2 * MAN_W + 2;  // full significand product
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, UNPACK, EXEC, NORM, DONE} state_t;
    state_t state;

    logic             op_q;
    logic [W-1:0]     a_q, b_q;
    logic             u_op, u_sa, u_sb, u_za, u_zb, u_ia, u_ib, u_na, u_nb;
    logic [EXP_W-1:0] u_ea, u_eb;
    logic [MAN_W:0]   u_ma, u_mb;

    logic                  x_sign, x_c, x_nan, x_inf;
    logic signed [XW-1:0]  x_exp;
    logic [SW-1:0]         x_sig;
    logic                  e_op, e_sign, e_c, e_nan, e_inf;
    logic signed [XW-1:0]  e_exp;
    logic [SW-1:0]         e_sig;

    logic             swap, big_s, sm_s;
    logic [EXP_W-1:0] big_e, sm_e, d;
    logic [MAN_W:0]   big_m, sm_m;
    logic [MAN_W+3:0] sm_ext, lost, al;
    logic [PW-1:0]    prod;

    logic [SW-2:0]        nsig;
    logic signed [XW-1:0] nexp;
    logic [MAN_W+1:0]     rnd;
    logic                 inc, n_c, n_v;
    int                   lz;
    logic [W-1:0]         n_res;
    logic [3:0]           n_flags;
    logic                 unused_bits;

    // Control FSM with registered handshake outputs and result/flags written on NORM->DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state    <= UNPACK;
                    in_ready <= 1'b0;
                end
                UNPACK: state <= EXEC;
                EXEC:   state <= NORM;
                NORM: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    result    <= n_res;
                    flags     <= n_flags;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Datapath stage registers: capture on handshake, unpack/classify, then hold the EXEC result.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
        if (state == UNPACK) begin
            u_op <= op_q;
            u_sa <= a_q[W-1];
            u_sb <= b_q[W-1];
            u_ea <= a_q[W-2:MAN_W];
            u_eb <= b_q[W-2:MAN_W];
            // Denormals flush to signed zero: no hidden bit, significand cleared.
            u_za <= (a_q[W-2:MAN_W] == '0);
            u_zb <= (b_q[W-2:MAN_W] == '0);
            u_ia <= (a_q[W-2:MAN_W] == EXP_ONES) && (a_q[MAN_W-1:0] == '0);
            u_ib <= (b_q[W-2:MAN_W] == EXP_ONES) && (b_q[MAN_W-1:0] == '0);
            u_na <= (a_q[W-2:MAN_W] == EXP_ONES) && (a_q[MAN_W-1:0] != '0);
            u_nb <= (b_q[W-2:MAN_W] == EXP_ONES) && (b_q[MAN_W-1:0] != '0);
            u_ma <= (a_q[W-2:MAN_W] == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
            u_mb <= (b_q[W-2:MAN_W] == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
        end
        if (state == EXEC) begin
            e_op   <= u_op;
            e_sign <= x_sign;
            e_exp  <= x_exp;
            e_sig  <= x_sig;
            e_c    <= x_c;
            e_nan  <= x_nan;
            e_inf  <= x_inf;
        end
    end

    // EXEC: align-and-add or multiply into a common {carry, hidden, mantissa, G, R, S} significand.
    always_comb begin
        swap = ({u_eb, u_mb} > {u_ea, u_ma});
        big_s = swap ? u_sb : u_sa;
        sm_s  = swap ? u_sa : u_sb;
        big_e = swap ? u_eb : u_ea;
        sm_e  = swap ? u_ea : u_eb;
        big_m = swap ? u_mb : u_ma;
        sm_m  = swap ? u_ma : u_mb;
        d      = big_e - sm_e;
        sm_ext = {sm_m, 3'b000};
        lost   = sm_ext & ~({(MAN_W+4){1'b1}} << d);
        al     = (sm_ext >> d) | {{(MAN_W+3){1'b0}}, |lost};
        prod   = {{(MAN_W+1){1'b0}}, u_ma} * {{(MAN_W+1){1'b0}}, u_mb};
        x_sign = 1'b0;
        x_exp  = '0;
        x_sig  = '0;
        x_c    = 1'b0;
        x_nan  = 1'b0;
        x_inf  = 1'b0;
        if (u_op) begin
            x_sign = u_sa ^ u_sb;
            x_exp  = $signed({{(XW-EXP_W){1'b0}}, u_ea}) + $signed({{(XW-EXP_W){1'b0}}, u_eb}) - BIAS;
            x_sig  = prod[PW-1:MAN_W-3] | {{(SW-1){1'b0}}, |prod[MAN_W-4:0]};
            x_nan  = u_na | u_nb | (u_ia & u_zb) | (u_za & u_ib);
            x_inf  = u_ia | u_ib;
        end else begin
            // Far-shifted operand contributes only to sticky.
            if (int'(d) >= MAN_W + 3)
                al = {{(MAN_W+3){1'b0}}, |sm_m};
            if (big_s == sm_s) begin
                x_sig = {1'b0, big_m, 3'b000} + {1'b0, al};
                x_c   = x_sig[SW-1];
            end else begin
                x_sig = {1'b0, big_m, 3'b000} - {1'b0, al};
            end
            x_sign = (u_ia | u_ib) ? (u_ia ? u_sa : u_sb) : big_s;
            x_exp  = $signed({{(XW-EXP_W){1'b0}}, big_e});
            x_nan  = u_na | u_nb | (u_ia & u_ib & (u_sa != u_sb));
            x_inf  = u_ia | u_ib;
        end
    end

    // NORM: renormalise, round, range-check and pack; flags derive from the packed word.
    always_comb begin
        nsig  = '0;
        nexp  = '0;
        rnd   = '0;
        inc   = 1'b0;
        lz    = 0;
        n_c   = 1'b0;
        n_v   = 1'b0;
        n_res = '0;
        if (e_nan) begin
            n_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            n_v   = 1'b1;
        end else if (e_inf) begin
            n_res = {e_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e_sig == '0) begin
            // An exact-zero sum is +0; a zero product keeps its sign.
            n_res = {e_op & e_sign, {(W-1){1'b0}}};
        end else begin
            if (e_sig[SW-1]) begin
                nsig = {e_sig[SW-1:2], |e_sig[1:0]};
                nexp = e_exp + XW'(1);
            end else begin
                for (int i = 0; i < SW - 1; i++)
                    if (e_sig[i]) lz = SW - 2 - i;
                nsig = e_sig[SW-2:0] << lz;
                nexp = e_exp - XW'(lz);
            end
`ifdef FPU_SEQ_RNE_EN
            inc = nsig[2] & (nsig[1] | nsig[0] | nsig[3]);
`endif
            rnd = {1'b0, nsig[SW-2:3]} + {{(MAN_W+1){1'b0}}, inc};
            if (rnd[MAN_W+1])
                nexp = nexp + XW'(1);
            n_c = e_c;
            if (nexp >= EMAX) begin
                n_res = {e_sign, EXP_ONES, {MAN_W{1'b0}}};
                n_v   = 1'b1;
            end else if (nexp < XW'(1)) begin
                n_res = {e_sign, {(W-1){1'b0}}};
            end else begin
                n_res = {e_sign, nexp[EXP_W-1:0], rnd[MAN_W+1] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0]};
            end
        end
        n_flags = {n_res[W-1], (n_res[W-2:0] == '0), n_c, n_v};
    end

    // Round bits are dropped in the truncating build; the hidden bit of rnd is never packed.
    assign unused_bits = ^{nsig[2:0], rnd[MAN_W]};
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: vector table plus hand-written handshake/reset sequences for fpu_seq.
// Checks single and half formats; a scoreboard queue pairs each handshake with its result.
// Latency is measured from the handshake cycle to the first out_valid cycle.
module tb_fpu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, op, out_ready, in_ready, out_valid;
    logic [31:0] a, b, result;
    logic [3:0]  flags;
    logic        h_in_valid, h_op, h_out_ready, h_in_ready, h_out_valid;
    logic [15:0] h_a, h_b, h_result;
    logic [3:0]  h_flags;

    fpu_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fpu_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .flags(h_flags)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          hs;
    } sb_t;

`ifdef FPU_SEQ_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif
    localparam int NV = 15;

    vec_t vt [NV];
    sb_t  sb [$];
    sb_t  sbh [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic ov_q = 1'b0;
    logic hov_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor for the single-precision instance.
    always @(negedge clk) begin
        sb_t e;
        if (out_valid === 1'b1 && ov_q !== 1'b1) begin
            if (sb.size() == 0) check("spurious_out_valid", 32'(out_valid), 32'd0);
            else                check("latency", cyc - sb[0].hs, 32'd4);
        end
        if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
            e = sb.pop_front();
            check("result", result, e.res);
            check("flags", 32'(flags), 32'(e.flg));
        end
        ov_q = out_valid;
    end

    // Monitor for the half-precision instance.
    always @(negedge clk) begin
        sb_t e;
        if (h_out_valid === 1'b1 && hov_q !== 1'b1) begin
            if (sbh.size() == 0) check("h_spurious_out_valid", 32'(h_out_valid), 32'd0);
            else                 check("h_latency", cyc - sbh[0].hs, 32'd4);
        end
        if (h_out_valid === 1'b1 && h_out_ready && sbh.size() != 0) begin
            e = sbh.pop_front();
            check("h_result", 32'(h_result), e.res);
            check("h_flags", 32'(h_flags), 32'(e.flg));
        end
        hov_q = h_out_valid;
    end

    task automatic issue(input bit h, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [3:0] f);
        sb_t e;
        int  n = 0;
        bit  ok = 1'b0;
        @(posedge clk); #1;
        if (h) begin h_in_valid = 1'b1; h_op = o; h_a = x[15:0]; h_b = y[15:0]; end
        else   begin in_valid = 1'b1; op = o; a = x; b = y; end
        while (!ok && n < 30) begin
            @(negedge clk);
            if ((h ? h_in_ready : in_ready) === 1'b1) ok = 1'b1;
            else n++;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept: in_ready stayed low, got 0, expected 1");
        end else begin
            e.res = r; e.flg = f; e.hs = cyc;
            if (h) sbh.push_back(e); else sb.push_back(e);
        end
        @(posedge clk); #1;
        if (h) h_in_valid = 1'b0; else in_valid = 1'b0;
    endtask

    task automatic drain(input bit h);
        int n = 0;
        while ((h ? sbh.size() : sb.size()) != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 30) begin
            fails++;
            $display("FAIL drain: result not delivered, got timeout, expected out_valid");
            if (h) sbh.delete(); else sb.delete();
        end
    endtask

    task automatic reset_in_exec(input bit h, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] r);
        logic seen = 1'b0;
        issue(h, 1'b0, x, y, r, 4'b0000);
        @(posedge clk); #1;          // unit is now in EXEC
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if (h) sbh.delete(); else sb.delete();
        @(negedge clk);
        check("rst_in_ready",  32'(h ? h_in_ready : in_ready), 32'd1);
        check("rst_out_valid", 32'(h ? h_out_valid : out_valid), 32'd0);
        check("rst_result",    h ? 32'(h_result) : result, 32'd0);
        check("rst_flags",     32'(h ? h_flags : flags), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | (h ? h_out_valid : out_valid);
        end
        check("rst_no_output", 32'(seen), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;

        vt[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
        vt[1]  = '{1'b1, 32'h40000000, 32'hC0400000, 32'hC0C00000, 4'b1000};
        vt[2]  = '{1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0010};
        vt[3]  = '{1'b1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0001};
        vt[4]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001};
        vt[5]  = '{1'b0, 32'h40400000, 32'hC0400000, 32'h00000000, 4'b0100};
        vt[6]  = '{1'b0, 32'h3F800000, 32'h33C00000, RND_EXP,      4'b0000};
        vt[7]  = '{1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0001};
        vt[8]  = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0001};
        vt[9]  = '{1'b1, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b1000};
        vt[10] = '{1'b1, 32'h3F800000, 32'h00000001, 32'h00000000, 4'b0100};
        vt[11] = '{1'b0, 32'h00400000, 32'h3F800000, 32'h3F800000, 4'b0000};
        vt[12] = '{1'b1, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0100};
        vt[13] = '{1'b0, 32'hC0000000, 32'h3F800000, 32'hBF800000, 4'b1000};
        vt[14] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",    32'(in_ready), 32'd1);
        check("reset_out_valid",   32'(out_valid), 32'd0);
        check("reset_result",      result, 32'd0);
        check("reset_flags",       32'(flags), 32'd0);
        check("h_reset_in_ready",  32'(h_in_ready), 32'd1);
        check("h_reset_out_valid", 32'(h_out_valid), 32'd0);
        check("h_reset_result",    32'(h_result), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(1'b0, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].flg);
            drain(1'b0);
        end

        // Backpressure: stall in DONE, ignore a new request, then release.
        out_ready = 1'b0;
        issue(1'b0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000);
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready), 32'd0);
            check("bp_result",    result, 32'h40400000);
            check("bp_flags",     32'(flags), 32'd0);
            @(posedge clk); #1;
            in_valid = 1'b1; op = 1'b1; a = 32'h40A00000; b = 32'h40A00000;
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_in_ready",  32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        issue(1'b0, 1'b1, 32'h40000000, 32'hC0400000, 32'hC0C00000, 4'b1000);
        drain(1'b0);

        // Reset during EXEC aborts the op; a fresh op then completes.
        reset_in_exec(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000);
        issue(1'b0, 1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
        drain(1'b0);

        // Half-precision instance.
        issue(1'b1, 1'b0, 32'h3C00, 32'h4000, 32'h4200, 4'b0000);
        drain(1'b1);
        issue(1'b1, 1'b1, 32'h3C00, 32'hC000, 32'hC000, 4'b1000);
        drain(1'b1);
        issue(1'b1, 1'b0, 32'h7BFF, 32'h7BFF, 32'h7C00, 4'b0011);
        drain(1'b1);
        reset_in_exec(1'b1, 32'h3C00, 32'h4000, 32'h4200);
        issue(1'b1, 1'b0, 32'h3C00, 32'h4000, 32'h4200, 4'b0000);
        drain(1'b1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpu_seq.md
# fpu_seq

Multi-cycle, parametrised IEEE-754-style floating-point unit for add, subtract-free add and multiply, with a valid/ready handshake on both sides. It is the next-generation FPU for the datapath: one instance handles any format set by `EXP_W`/`MAN_W`, and it produces the same NZCV flag set as the current single-cycle FPU. Results and flags are registered, so the core can stall on the unit instead of closing timing through a combinational FP path.

## Interface
- `EXP_W`, 8, exponent width in bits.
- `MAN_W`, 23, stored mantissa width in bits (hidden bit excluded).
- `W`, derived, equals `1+EXP_W+MAN_W`; must not be overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  operands and `op` are valid.
- `in_ready`  out  1  the unit can accept an operation; high only in IDLE.
- `op`  in  1  0 = add, 1 = multiply.
- `a`, `b`  in  W  operands: {sign, exponent, mantissa}.
- `out_valid`  out  1  `result` and `flags` are valid; high only in DONE.
- `out_ready`  in  1  the consumer takes the result.
- `result`  out  W  registered result.
- `flags`  out  4  registered {N,Z,C,V}.

## Operation
- FSM states and transitions:
  - IDLE → UNPACK on `in_valid && in_ready`; `a`, `b` and `op` are captured on that edge.
  - UNPACK → EXEC → NORM → DONE unconditionally.
  - DONE → IDLE on `out_ready`.
- UNPACK:
  - Split each operand into sign, exponent and significand, with the hidden bit set when the exponent is nonzero.
  - Classify each operand as zero, inf or NaN. Denormal inputs are flushed to signed zero.
- EXEC, add:
  - Swap the operands so the larger magnitude comes first.
  - Right-shift the smaller significand by the exponent difference. Bits shifted out collect into guard/round/sticky; a difference ≥ MAN_W+3 leaves only sticky.
  - Add or subtract the magnitudes according to the signs.
- EXEC, multiply:
  - Sign = XOR of the operand signs.
  - Exponent = ea+eb−bias, where bias = 2^(EXP_W−1)−1.
  - Form the (2·MAN_W+2)-bit significand product.
- NORM:
  - Renormalise: one right shift on carry-out, or a leading-zero left shift.
  - Round (see Configuration).
  - Pack the result. Exponent ≥ all-ones gives ±inf. Exponent ≤ 0 gives ±0 (no denormal outputs).
- Special cases:
  - Any NaN input, inf−inf, or inf×0 gives the canonical NaN: sign 0, exponent all ones, mantissa MSB 1, all other mantissa bits 0.
  - inf op finite gives inf with the correct sign.
  - An exact-zero sum gives +0.
- Flags:
  - N = result sign bit.
  - Z = 1 when the result exponent and mantissa are both 0.
  - C = add only: the aligned significand addition carried out. Always 0 for multiply.
  - V = 1 on overflow to inf from finite operands, or on a NaN result.
- `result` and `flags` are written only on the NORM→DONE edge. They hold their values through DONE and afterwards until the next write.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `flags` 0. These take effect on the first edge with `reset` high.
- Latency: a handshake in cycle k makes `out_valid` high in cycle k+4.
- Throughput: one operation per 5 cycles when `out_ready` is held high.
- No accept-in-DONE bypass. After the DONE→IDLE edge, `in_ready` rises in the following cycle.
- Backpressure: with `out_ready` low, the unit stays in DONE indefinitely, with `result` and `flags` stable and `in_ready` 0.
- `in_valid` while `in_ready` is 0 is ignored. Operands are not re-sampled after capture.
- Reset mid-operation (any state) aborts the operation: next cycle is IDLE, `out_valid` 0, `result`/`flags` 0, and no output is produced.
- Reset has priority over a handshake in the same cycle.

## Configuration
- `FPU_SEQ_RNE_EN`
  - Defined: NORM rounds to nearest, ties to even, using guard/round/sticky. A rounding carry that overflows the mantissa increments the exponent and may produce inf with V=1.
  - Undefined: NORM truncates (round toward zero) and guard/round/sticky are discarded.
- Latency and interface are identical in both builds.

## Test plan
- Default format, add 0x3F800000 + 0x40000000 (1.0+2.0) → `result` 0x40400000, `flags` 0000, `out_valid` exactly 4 cycles after the handshake.
- Mul 0x40000000 × 0xC0400000 (2.0×−3.0) → 0xC0C00000, `flags` 1000. Add 0x3FC00000 + 0x3FC00000 (1.5+1.5) → 0x40400000, `flags` 0010.
- Mul 0x7F7FFFFF × 0x40000000 → 0x7F800000, `flags` 0001. Add 0x7F800000 + 0xFF800000 → 0x7FC00000, `flags` 0001. Add 0x40400000 + 0xC0400000 → 0x00000000, `flags` 0100.
- Add 0x3F800000 + 0x33C00000 → 0x3F800001 with `FPU_SEQ_RNE_EN`, 0x3F800000 without.
- Hold `out_ready` low 3 cycles in DONE: `result`, `flags` and `out_valid` stay stable, `in_ready` stays 0, and a new `in_valid` is ignored. Raise `out_ready`: IDLE next cycle, the next op is accepted, and its `out_valid` arrives 4 cycles after its handshake.
- Assert `reset` during EXEC: `out_valid` never rises for that op, outputs are 0, and a fresh op issued after reset completes correctly. Repeat with `EXP_W`=5, `MAN_W`=10: 0x3C00 + 0x4000 → 0x4200.
